// File: rtl/gen3_scrambler_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// gen3_scrambler_ctrl_pkg
// Shared definitions for the Gen3 128b/130b scrambler control slice:
//   - block type encodings carried on blk_type_i
//   - sync header values (data block vs. ordered set)
//   - block geometry (words per block, index of the last word)
//   - FSM state enum
//   - per-byte training-sequence (no-scramble) masks
// ---------------------------------------------------------------------------
package gen3_scrambler_ctrl_pkg;

  typedef enum logic [1:0] {
    BLK_DATA  = 2'b00,
    BLK_TS    = 2'b01,
    BLK_EIEOS = 2'b10,
    BLK_SKP   = 2'b11
  } blk_type_e;

  localparam logic [1:0] HDR_DATA = 2'b10;
  localparam logic [1:0] HDR_OS   = 2'b01;

  localparam int         WORDS_PER_BLOCK = 4;
  localparam logic [1:0] LAST_WORD       = 2'(WORDS_PER_BLOCK - 1);

  // Every word handed to the scrambler carries four bytes.
  localparam logic [1:0] SC_LEN_4B = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PAYLOAD = 2'b01,
    ST_SEED    = 2'b10
  } state_e;

  localparam logic [3:0] TS_MASK_NONE = 4'b0000;
  localparam logic [3:0] TS_MASK_SYM0 = 4'b0001;
  localparam logic [3:0] TS_MASK_ALL  = 4'b1111;

endpackage

// File: rtl/gen3_scrambler_ctrl.sv
// ---------------------------------------------------------------------------
// gen3_scrambler_ctrl
// Frames 16-byte Gen3 blocks (4 x 32-bit words) towards a lane scrambler.
// A block descriptor is accepted in IDLE, then four payload words are passed
// straight through (zero latency) with the per-word scramble enable, the
// no-scramble byte mask and the sync header for the first word. EIEOS blocks
// are followed by a one-cycle LFSR reseed pulse.
//
// Optional build macro: GEN3_SCR_CTRL_BYPASS_EN adds bypass_i, which forces
// every block to be sent unscrambled while framing and the EIEOS reseed
// pulse stay unchanged.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   bypass_i             (macro only) disable scrambling for all blocks
//   blk_valid_i/ready_o  block descriptor handshake, blk_type_i its type
//   wdata_i/wvalid_i     payload word in, wready_o accepted
//   out_ready_i          downstream can take a word
//   sc_valid_o/sc_data_o word to the scrambler
//   sc_datak_o           per-byte K flag (always 0)
//   sc_ts_o              per-byte no-scramble mask
//   sc_len_o             bytes per word (fixed 4)
//   sc_en_o              scramble / LFSR-advance enable
//   sc_hdr_o, sc_sob_o   sync header and start-of-block on word 0
//   seed_load_o          LFSR reseed pulse after EIEOS
//   blk_cnt_o            completed block count (wraps)
// ---------------------------------------------------------------------------
module gen3_scrambler_ctrl
  import gen3_scrambler_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef GEN3_SCR_CTRL_BYPASS_EN
  input  logic        bypass_i,
`endif
  input  logic        blk_valid_i,
  output logic        blk_ready_o,
  input  logic [1:0]  blk_type_i,
  input  logic [31:0] wdata_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  input  logic        out_ready_i,
  output logic        sc_valid_o,
  output logic [31:0] sc_data_o,
  output logic [3:0]  sc_datak_o,
  output logic [3:0]  sc_ts_o,
  output logic [1:0]  sc_len_o,
  output logic        sc_en_o,
  output logic [1:0]  sc_hdr_o,
  output logic        sc_sob_o,
  output logic        seed_load_o,
  output logic [7:0]  blk_cnt_o
);

  state_e     state_q, state_d;
  blk_type_e  type_q;
  logic [1:0] word_cnt_q;
  logic [7:0] blk_cnt_q;
  logic       xfer;
  logic       last_word;

  assign xfer      = (state_q == ST_PAYLOAD) && wvalid_i && out_ready_i;
  assign last_word = (word_cnt_q == LAST_WORD);

  assign sc_data_o  = wdata_i;
  assign sc_datak_o = 4'b0000;
  assign sc_len_o   = SC_LEN_4B;
  assign blk_cnt_o  = blk_cnt_q;

  // State, latched block type, word index and completed-block counter.
  // word_cnt only moves on a real transfer, so a stall freezes every
  // registered input to the output decode.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      type_q     <= BLK_DATA;
      word_cnt_q <= 2'd0;
      blk_cnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && blk_valid_i) begin
        type_q     <= blk_type_e'(blk_type_i);
        word_cnt_q <= 2'd0;
      end else if (xfer) begin
        word_cnt_q <= word_cnt_q + 2'd1;
        if (last_word) begin
          blk_cnt_q <= blk_cnt_q + 8'd1;
        end
      end
    end
  end

  // Next-state and output decode. Outside PAYLOAD everything towards the
  // scrambler is quiet; SEED only raises the reseed pulse.
  always_comb begin
    state_d     = state_q;
    blk_ready_o = 1'b0;
    wready_o    = 1'b0;
    sc_valid_o  = 1'b0;
    sc_en_o     = 1'b0;
    sc_ts_o     = TS_MASK_NONE;
    sc_hdr_o    = 2'b00;
    sc_sob_o    = 1'b0;
    seed_load_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        blk_ready_o = 1'b1;
        if (blk_valid_i) begin
          state_d = ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        wready_o   = out_ready_i;
        sc_valid_o = wvalid_i;

        if (word_cnt_q == 2'd0) begin
          sc_sob_o = 1'b1;
          sc_hdr_o = (type_q == BLK_DATA) ? HDR_DATA : HDR_OS;
        end

        // TS blocks leave only symbol 0 of the first word unscrambled;
        // EIEOS and SKP are sent raw and must not advance the LFSR.
        case (type_q)
          BLK_DATA: begin
            sc_en_o = 1'b1;
            sc_ts_o = TS_MASK_NONE;
          end
          BLK_TS: begin
            sc_en_o = 1'b1;
            sc_ts_o = (word_cnt_q == 2'd0) ? TS_MASK_SYM0 : TS_MASK_NONE;
          end
          default: begin
            sc_en_o = 1'b0;
            sc_ts_o = TS_MASK_ALL;
          end
        endcase

`ifdef GEN3_SCR_CTRL_BYPASS_EN
        if (bypass_i) begin
          sc_en_o = 1'b0;
          sc_ts_o = TS_MASK_ALL;
        end
`endif

        if (xfer && last_word) begin
          state_d = (type_q == BLK_EIEOS) ? ST_SEED : ST_IDLE;
        end
      end

      ST_SEED: begin
        seed_load_o = 1'b1;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gen3_scrambler_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gen3_scrambler_ctrl
// Self-checking bench for gen3_scrambler_ctrl. Expected beats are pushed to
// a queue as payload words are driven; a monitor captures every word that
// actually transfers, and each scenario task pops and compares both queues.
// ---------------------------------------------------------------------------
module tb_gen3_scrambler_ctrl;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  hdr;
    logic        sob;
    logic        en;
    logic [3:0]  ts;
    logic [3:0]  datak;
    logic [1:0]  len;
  } beat_t;

  logic        clk_i;
  logic        rst_i;
  logic        blk_valid_i;
  logic        blk_ready_o;
  logic [1:0]  blk_type_i;
  logic [31:0] wdata_i;
  logic        wvalid_i;
  logic        wready_o;
  logic        out_ready_i;
  logic        sc_valid_o;
  logic [31:0] sc_data_o;
  logic [3:0]  sc_datak_o;
  logic [3:0]  sc_ts_o;
  logic [1:0]  sc_len_o;
  logic        sc_en_o;
  logic [1:0]  sc_hdr_o;
  logic        sc_sob_o;
  logic        seed_load_o;
  logic [7:0]  blk_cnt_o;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    errors;
  int    checks;
  int    seed_seen;
  logic [7:0] exp_cnt;

  gen3_scrambler_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
`ifdef GEN3_SCR_CTRL_BYPASS_EN
    .bypass_i    (1'b0),
`endif
    .blk_valid_i (blk_valid_i),
    .blk_ready_o (blk_ready_o),
    .blk_type_i  (blk_type_i),
    .wdata_i     (wdata_i),
    .wvalid_i    (wvalid_i),
    .wready_o    (wready_o),
    .out_ready_i (out_ready_i),
    .sc_valid_o  (sc_valid_o),
    .sc_data_o   (sc_data_o),
    .sc_datak_o  (sc_datak_o),
    .sc_ts_o     (sc_ts_o),
    .sc_len_o    (sc_len_o),
    .sc_en_o     (sc_en_o),
    .sc_hdr_o    (sc_hdr_o),
    .sc_sob_o    (sc_sob_o),
    .seed_load_o (seed_load_o),
    .blk_cnt_o   (blk_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Capture every word that the downstream accepts, plus reseed pulses.
  always @(negedge clk_i) begin
    if (!rst_i && sc_valid_o && out_ready_i) begin
      obs_q.push_back('{sc_data_o, sc_hdr_o, sc_sob_o, sc_en_o, sc_ts_o, sc_datak_o, sc_len_o});
    end
    if (!rst_i && seed_load_o) begin
      seed_seen++;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time expired, want completion");
    $fatal(1, "[TB] watchdog");
  end

  // Reference behaviour of one transferred word.
  function automatic beat_t model(input logic [1:0] t, input int w, input logic [31:0] d);
    beat_t b;
    b.data  = d;
    b.sob   = (w == 0);
    b.hdr   = (w != 0) ? 2'b00 : ((t == 2'b00) ? 2'b10 : 2'b01);
    b.en    = (t == 2'b00) || (t == 2'b01);
    b.ts    = (t == 2'b00) ? 4'h0 : (t == 2'b01) ? ((w == 0) ? 4'h1 : 4'h0) : 4'hF;
    b.datak = 4'h0;
    b.len   = 2'b10;
    return b;
  endfunction

  // Stimulus only: wait for the descriptor slot, then push four words.
  task automatic wait_ready();
    int n;
    n = 0;
    while (!blk_ready_o && n < 20) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!blk_ready_o) begin
      checks++; errors++;
      $display("[TB] FAIL ready_timeout: blk_ready_o=%0b after %0d cycles, want 1", blk_ready_o, n);
    end
  endtask

  task automatic drive_block(input logic [1:0] t, input logic [31:0] base);
    wait_ready();
    blk_valid_i = 1'b1;
    blk_type_i  = t;
    @(posedge clk_i); #1;
    blk_valid_i = 1'b0;
    for (int w = 0; w < 4; w++) begin
      wdata_i     = base + 32'(w) * 32'h11111111;
      wvalid_i    = 1'b1;
      out_ready_i = 1'b1;
      exp_q.push_back(model(t, w, wdata_i));
      @(posedge clk_i); #1;
    end
    wvalid_i = 1'b0;
    exp_cnt  = exp_cnt + 8'd1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    #3;
    checks++;
    if ({blk_cnt_o, seed_load_o, sc_valid_o, wready_o, sc_en_o, sc_ts_o, sc_hdr_o, sc_sob_o, sc_datak_o, sc_len_o} !== {8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'b00, 1'b0, 4'h0, 2'b10}) begin
      errors++;
      $display("[TB] FAIL reset_outputs: cnt=%0d seed=%0b v=%0b wr=%0b en=%0b ts=%h hdr=%b sob=%0b k=%h len=%b, want 0 0 0 0 0 0 00 0 0 10",
               blk_cnt_o, seed_load_o, sc_valid_o, wready_o, sc_en_o, sc_ts_o, sc_hdr_o, sc_sob_o, sc_datak_o, sc_len_o);
    end
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;
    #3;
    checks++;
    if (blk_ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready: blk_ready_o=%0b, want 1", blk_ready_o);
    end
    checks++;
    if (blk_cnt_o !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_cnt: blk_cnt_o=%0d, want 0", blk_cnt_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_data();
    beat_t e, o;
    drive_block(2'b00, 32'h11111111);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("[TB] FAIL data_count: got %0d transfers, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL data_beat: got %h, want %h", o, e);
      end
    end
    exp_q.delete(); obs_q.delete();
    checks++;
    if (blk_cnt_o !== exp_cnt) begin
      errors++;
      $display("[TB] FAIL data_cnt: blk_cnt_o=%0d, want %0d", blk_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_ts();
    beat_t e, o;
    drive_block(2'b01, 32'hA5A50000);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("[TB] FAIL ts_count: got %0d transfers, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL ts_beat: got %h, want %h", o, e);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_eieos();
    beat_t e, o;
    drive_block(2'b10, 32'h00FF00FF);
    checks++;
    if ({seed_load_o, blk_ready_o} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL eieos_seed: seed_load_o=%0b blk_ready_o=%0b, want 1 0", seed_load_o, blk_ready_o);
    end
    @(posedge clk_i); #1;
    checks++;
    if ({seed_load_o, blk_ready_o} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL eieos_after: seed_load_o=%0b blk_ready_o=%0b, want 0 1", seed_load_o, blk_ready_o);
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("[TB] FAIL eieos_count: got %0d transfers, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL eieos_beat: got %h, want %h", o, e);
      end
    end
    exp_q.delete(); obs_q.delete();
    checks++;
    if (seed_seen !== 1) begin
      errors++;
      $display("[TB] FAIL eieos_pulses: saw %0d seed pulses, want 1", seed_seen);
    end
  endtask

  task automatic test_skp_then_data();
    beat_t e, o;
    drive_block(2'b11, 32'h12340000);
    checks++;
    if ({seed_load_o, blk_ready_o} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL skp_after: seed_load_o=%0b blk_ready_o=%0b, want 0 1", seed_load_o, blk_ready_o);
    end
    drive_block(2'b00, 32'h55555555);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("[TB] FAIL skp_count: got %0d transfers, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL skp_beat: got %h, want %h", o, e);
      end
    end
    exp_q.delete(); obs_q.delete();
    @(posedge clk_i); #1;
    checks++;
    if (seed_seen !== 1 || blk_cnt_o !== exp_cnt) begin
      errors++;
      $display("[TB] FAIL skp_totals: seeds=%0d cnt=%0d, want 1 %0d", seed_seen, blk_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_stall();
    beat_t e, o;
    wait_ready();
    blk_valid_i = 1'b1;
    blk_type_i  = 2'b00;
    @(posedge clk_i); #1;
    blk_valid_i = 1'b0;
    for (int w = 0; w < 4; w++) begin
      wdata_i  = 32'hC0DE0000 + 32'(w);
      wvalid_i = 1'b1;
      exp_q.push_back(model(2'b00, w, wdata_i));
      if (w == 1) begin
        out_ready_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #3;
          checks++;
          if ({wready_o, sc_valid_o, sc_data_o, sc_sob_o, sc_hdr_o, sc_en_o} !== {1'b0, 1'b1, 32'hC0DE0001, 1'b0, 2'b00, 1'b1}) begin
            errors++;
            $display("[TB] FAIL stall_hold: wr=%0b v=%0b d=%h sob=%0b hdr=%b en=%0b, want 0 1 c0de0001 0 00 1",
                     wready_o, sc_valid_o, sc_data_o, sc_sob_o, sc_hdr_o, sc_en_o);
          end
          @(posedge clk_i); #1;
        end
      end
      out_ready_i = 1'b1;
      @(posedge clk_i); #1;
    end
    wvalid_i = 1'b0;
    exp_cnt  = exp_cnt + 8'd1;
    checks++;
    if (obs_q.size() !== 4) begin
      errors++;
      $display("[TB] FAIL stall_count: got %0d transfers, want 4", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL stall_beat: got %h, want %h", o, e);
      end
    end
    exp_q.delete(); obs_q.delete();
    checks++;
    if (blk_cnt_o !== exp_cnt) begin
      errors++;
      $display("[TB] FAIL stall_cnt: blk_cnt_o=%0d, want %0d", blk_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_reset_wrap();
    beat_t e, o;
    int    seeds_before;
    seeds_before = seed_seen;
    wait_ready();
    blk_valid_i = 1'b1;
    blk_type_i  = 2'b10;
    @(posedge clk_i); #1;
    blk_valid_i = 1'b0;
    for (int w = 0; w < 3; w++) begin
      wdata_i     = 32'hDEAD0000 + 32'(w);
      wvalid_i    = 1'b1;
      out_ready_i = 1'b1;
      if (w < 2) begin
        @(posedge clk_i); #1;
      end
    end
    #2;
    rst_i = 1'b1;
    #1;
    checks++;
    if ({blk_ready_o, sc_valid_o, wready_o, sc_sob_o, seed_load_o, blk_cnt_o} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("[TB] FAIL midblock_reset: rdy=%0b v=%0b wr=%0b sob=%0b seed=%0b cnt=%0d, want 1 0 0 0 0 0",
               blk_ready_o, sc_valid_o, wready_o, sc_sob_o, seed_load_o, blk_cnt_o);
    end
    wvalid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    exp_cnt = 8'd0;
    obs_q.delete(); exp_q.delete();
    @(posedge clk_i); #1;
    checks++;
    if (seed_seen !== seeds_before || blk_ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midblock_noseed: seeds=%0d rdy=%0b, want %0d 1", seed_seen, blk_ready_o, seeds_before);
    end
    for (int i = 0; i < 256; i++) begin
      drive_block(2'b00, 32'(i) << 8);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
        errors++;
        $display("[TB] FAIL wrap_count: block %0d got %0d transfers, want %0d", i, obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        checks++;
        if (o !== e) begin
          errors++;
          $display("[TB] FAIL wrap_beat: block %0d got %h, want %h", i, o, e);
        end
      end
      exp_q.delete(); obs_q.delete();
      if (i == 254) begin
        checks++;
        if (blk_cnt_o !== 8'd255) begin
          errors++;
          $display("[TB] FAIL wrap_255: blk_cnt_o=%0d, want 255", blk_cnt_o);
        end
      end
    end
    checks++;
    if (blk_cnt_o !== exp_cnt || exp_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL wrap_zero: blk_cnt_o=%0d, want 0", blk_cnt_o);
    end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    seed_seen   = 0;
    exp_cnt     = 8'd0;
    rst_i       = 1'b1;
    blk_valid_i = 1'b0;
    blk_type_i  = 2'b00;
    wdata_i     = 32'h0;
    wvalid_i    = 1'b0;
    out_ready_i = 1'b0;

    test_reset();
    test_data();
    test_ts();
    test_eieos();
    test_skp_then_data();
    test_stall();
    test_reset_wrap();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
